mem_dump_arbiter: RTL

Shares the single read/write port pair of the `memory_32` data memory between the CPU MEM stage and the debug unit. In normal run the CPU passes straight through to memory. On a debug request the block stalls the CPU, reads every memory word in order, and streams the words out over a valid/ready interface for the UART dump. It sits between the MEM stage, the debug unit and `memory_32`.

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_port_mux.sv | 50 +++++
 rtl/mem_dump_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory control slice.
//   - memory_32 addressing-mode encodings (WORD / HALF / BYTE)
//   - dump FSM state type used by mem_dump_arbiter
package mem_ctrl_pkg;

   localparam logic [1:0] WORD = 2'b00;
   localparam logic [1:0] HALF = 2'b01;
   localparam logic [1:0] BYTE = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } dump_state_t;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational selector for the memory_32 port pair.
// When i_dump_own is low the CPU request passes straight through; when high
// the dump FSM owns the read port and all writes are suppressed.
// Ports:
//   i_dump_own                      - dump FSM owns the memory (not IDLE)
//   i_fsm_r_en, i_fsm_r_addr        - dump read request
//   i_cpu_r_*, i_cpu_w_*            - CPU MEM-stage request
//   o_mem_r_*, o_mem_w_*            - memory_32 port drive
module mem_port_mux
   import mem_ctrl_pkg::*;
#(
   parameter int NB_DATA_BUS = 32,
   parameter int NB_ADDRESS  = 6
) (
   input  logic                   i_dump_own,
   input  logic                   i_fsm_r_en,
   input  logic [NB_ADDRESS-1:0]  i_fsm_r_addr,
   input  logic                   i_cpu_r_en,
   input  logic [NB_ADDRESS-1:0]  i_cpu_r_addr,
   input  logic [1:0]             i_cpu_r_addressing,
   input  logic                   i_cpu_w_en,
   input  logic [NB_ADDRESS-1:0]  i_cpu_w_addr,
   input  logic [NB_DATA_BUS-1:0] i_cpu_w_data,
   input  logic [1:0]             i_cpu_w_addressing,
   output logic                   o_mem_r_en,
   output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
   output logic [1:0]             o_mem_r_addressing,
   output logic                   o_mem_w_en,
   output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
   output logic [NB_DATA_BUS-1:0] o_mem_w_data,
   output logic [1:0]             o_mem_w_addressing
);

   always_comb begin
      o_mem_r_en         = i_cpu_r_en;
      o_mem_r_addr       = i_cpu_r_addr;
      o_mem_r_addressing = i_cpu_r_addressing;
      o_mem_w_en         = i_cpu_w_en;
      o_mem_w_addr       = i_cpu_w_addr;
      o_mem_w_data       = i_cpu_w_data;
      o_mem_w_addressing = i_cpu_w_addressing;
      if (i_dump_own) begin
         o_mem_r_en         = i_fsm_r_en;
         o_mem_r_addr       = i_fsm_r_addr;
         o_mem_r_addressing = WORD;
         o_mem_w_en         = 1'b0;
      end
   end

endmodule

// File: rtl/mem_dump_arbiter.sv
// Arbitrates the memory_32 port pair between the CPU MEM stage and the debug
// dump. On i_dump_start the CPU is stalled, every memory word is read in
// address order and streamed out on a valid/ready interface.
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append one extra beat
// carrying the XOR of all dumped words (o_dump_last then marks that beat).
// Ports:
//   i_clk, i_rst_n                    - clock, async active-low reset
//   i_cpu_r_*, i_cpu_w_*, o_cpu_r_data - CPU memory request / read data
//   o_cpu_stall                       - dump owns the memory
//   i_dump_start, o_dump_busy         - dump request / FSM not idle
//   o_dump_data/valid/last, i_dump_ready - dump stream
//   o_dump_done                       - end-of-dump pulse
//   o_mem_*, i_mem_r_data             - memory_32 ports
//
// state | meaning
// IDLE  | CPU passes through to memory
// READ  | word read issued at {counter, 2'b00}
// WAIT  | read data returning, captured on exit
// SEND  | beat presented, waits for ready
// DONE  | one-cycle completion pulse
module mem_dump_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int NB_DATA_BUS = 32,
   parameter int NB_ADDRESS  = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cpu_r_en,
   input  logic [NB_ADDRESS-1:0]  i_cpu_r_addr,
   input  logic [1:0]             i_cpu_r_addressing,
   input  logic                   i_cpu_w_en,
   input  logic [NB_ADDRESS-1:0]  i_cpu_w_addr,
   input  logic [NB_DATA_BUS-1:0] i_cpu_w_data,
   input  logic [1:0]             i_cpu_w_addressing,
   output logic [NB_DATA_BUS-1:0] o_cpu_r_data,
   output logic                   o_cpu_stall,
   input  logic                   i_dump_start,
   output logic                   o_dump_busy,
   output logic [NB_DATA_BUS-1:0] o_dump_data,
   output logic                   o_dump_valid,
   input  logic                   i_dump_ready,
   output logic                   o_dump_last,
   output logic                   o_dump_done,
   output logic                   o_mem_r_en,
   output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
   output logic [1:0]             o_mem_r_addressing,
   output logic                   o_mem_w_en,
   output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
   output logic [NB_DATA_BUS-1:0] o_mem_w_data,
   output logic [1:0]             o_mem_w_addressing,
   input  logic [NB_DATA_BUS-1:0] i_mem_r_data
);

   localparam int NB_CNT = NB_ADDRESS - 2;

   dump_state_t            state_q, state_d;
   logic [NB_CNT-1:0]      cnt_q;
   logic [NB_DATA_BUS-1:0] dump_data_q;
   logic                   dump_last_q;
   logic                   stall_q;
   logic                   beat_done;
   logic                   last_word;
   logic                   start_ok;

   assign start_ok  = (state_q == IDLE) && i_dump_start;
   assign beat_done = (state_q == SEND) && i_dump_ready;
   assign last_word = &cnt_q;

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [NB_DATA_BUS-1:0] chk_q;
   logic                   chk_beat_q;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_dump_start) state_d = READ;
         READ: state_d = WAIT;
         WAIT: state_d = SEND;
         SEND: begin
            if (beat_done) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               // last memory word loops back into SEND for the checksum beat
               if (chk_beat_q)     state_d = DONE;
               else if (last_word) state_d = SEND;
               else                state_d = READ;
`else
               if (last_word) state_d = DONE;
               else           state_d = READ;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dump_data_q <= '0;
         dump_last_q <= 1'b0;
         stall_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         chk_q       <= '0;
         chk_beat_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         stall_q <= (state_d != IDLE);
         if (start_ok)
            cnt_q <= '0;
         else if (beat_done && !last_word)
            cnt_q <= cnt_q + 1'b1;
         if (state_q == WAIT) begin
            dump_data_q <= i_mem_r_data;
`ifdef MEM_DUMP_CHECKSUM_EN
            dump_last_q <= 1'b0;
`else
            dump_last_q <= last_word;
`endif
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         if (start_ok) begin
            chk_q      <= '0;
            chk_beat_q <= 1'b0;
         end else if (state_q == WAIT) begin
            chk_q <= chk_q ^ i_mem_r_data;
         end else if (beat_done && last_word && !chk_beat_q) begin
            // chk_q already folds in the final word captured in WAIT
            dump_data_q <= chk_q;
            dump_last_q <= 1'b1;
            chk_beat_q  <= 1'b1;
         end
`endif
      end
   end

   assign o_cpu_r_data = i_mem_r_data;
   assign o_cpu_stall  = stall_q;
   assign o_dump_busy  = (state_q != IDLE);
   assign o_dump_data  = dump_data_q;
   assign o_dump_valid = (state_q == SEND);
   assign o_dump_last  = dump_last_q;
   assign o_dump_done  = (state_q == DONE);

   mem_port_mux #(
      .NB_DATA_BUS (NB_DATA_BUS),
      .NB_ADDRESS  (NB_ADDRESS)
   ) u_mux (
      .i_dump_own         (state_q != IDLE),
      .i_fsm_r_en         (state_q == READ),
      .i_fsm_r_addr       ({cnt_q, 2'b00}),
      .i_cpu_r_en         (i_cpu_r_en),
      .i_cpu_r_addr       (i_cpu_r_addr),
      .i_cpu_r_addressing (i_cpu_r_addressing),
      .i_cpu_w_en         (i_cpu_w_en),
      .i_cpu_w_addr       (i_cpu_w_addr),
      .i_cpu_w_data       (i_cpu_w_data),
      .i_cpu_w_addressing (i_cpu_w_addressing),
      .o_mem_r_en         (o_mem_r_en),
      .o_mem_r_addr       (o_mem_r_addr),
      .o_mem_r_addressing (o_mem_r_addressing),
      .o_mem_w_en         (o_mem_w_en),
      .o_mem_w_addr       (o_mem_w_addr),
      .o_mem_w_data       (o_mem_w_data),
      .o_mem_w_addressing (o_mem_w_addressing)
   );

endmodule
